// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the divider front-end.
//   div_state_e  : controller FSM states.
//   abs_val      : magnitude of a width-bit value that has been zero-extended to FN_W bits.
//   apply_sign   : conditional two's-complement negation.
//   DIV_ZERO_Q   : quotient pattern reported for a zero divisor (all ones).
// Helpers work on FN_W-bit containers. The caller slices the low D_WIDTH bits,
// so D_WIDTH must be below FN_W.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        RESULT = 2'd3
    } div_state_e;

    localparam int FN_W = 32;

    localparam logic [FN_W-1:0] DIV_ZERO_Q = '1;

    // The sign bit sits at position width-1 of the zero-extended value. The
    // low width bits of the 32-bit negation are the width-bit negation.
    function automatic logic [FN_W-1:0] abs_val(input logic [FN_W-1:0] value,
                                                input int              width,
                                                input logic            signed_en);
        if (signed_en && value[width-1]) begin
            return -value;
        end
        return value;
    endfunction

    function automatic logic [FN_W-1:0] apply_sign(input logic [FN_W-1:0] value,
                                                   input logic            neg);
        return neg ? -value : value;
    endfunction

endpackage

// File: rtl/div_sign_adjust.sv
// div_sign_adjust: combinational sign handling around the unsigned divider.
//   dividend/divisor        : raw request operands
//   mag_dividend/mag_divisor: magnitudes handed to the divider
//   quot_neg/rem_neg        : signs the final result must carry, derived from the raw operands
//   div_quotient/remainder  : unsigned divider results
//   quot_neg_q/rem_neg_q    : signs registered when the request was accepted
//   fixed_quotient/remainder: divider results with the signs restored
// With SIGNED=0 everything passes straight through.
module div_sign_adjust
    import div_pkg::*;
#(
    parameter int D_WIDTH = 4,
    parameter int SIGNED  = 0
) (
    input  logic [D_WIDTH-1:0] dividend,
    input  logic [D_WIDTH-1:0] divisor,
    output logic [D_WIDTH-1:0] mag_dividend,
    output logic [D_WIDTH-1:0] mag_divisor,
    output logic               quot_neg,
    output logic               rem_neg,
    input  logic [D_WIDTH-1:0] div_quotient,
    input  logic [D_WIDTH-1:0] div_remainder,
    input  logic               quot_neg_q,
    input  logic               rem_neg_q,
    output logic [D_WIDTH-1:0] fixed_quotient,
    output logic [D_WIDTH-1:0] fixed_remainder
);

    localparam logic SIGNED_EN = (SIGNED != 0);

    logic [FN_W-1:0] mag_dividend_w;
    logic [FN_W-1:0] mag_divisor_w;
    logic [FN_W-1:0] fixed_quotient_w;
    logic [FN_W-1:0] fixed_remainder_w;
    logic            unused_hi;

    assign mag_dividend_w    = abs_val(FN_W'(dividend), D_WIDTH, SIGNED_EN);
    assign mag_divisor_w     = abs_val(FN_W'(divisor), D_WIDTH, SIGNED_EN);
    assign fixed_quotient_w  = apply_sign(FN_W'(div_quotient), quot_neg_q);
    assign fixed_remainder_w = apply_sign(FN_W'(div_remainder), rem_neg_q);

    assign mag_dividend    = mag_dividend_w[D_WIDTH-1:0];
    assign mag_divisor     = mag_divisor_w[D_WIDTH-1:0];
    assign fixed_quotient  = fixed_quotient_w[D_WIDTH-1:0];
    assign fixed_remainder = fixed_remainder_w[D_WIDTH-1:0];

    // Truncating toward zero: the quotient is negative when the operand signs
    // differ, and the remainder follows the dividend.
    assign quot_neg = SIGNED_EN && (dividend[D_WIDTH-1] ^ divisor[D_WIDTH-1]);
    assign rem_neg  = SIGNED_EN && dividend[D_WIDTH-1];

    // The upper container bits are never used.
    assign unused_hi = ^{mag_dividend_w[FN_W-1:D_WIDTH], mag_divisor_w[FN_W-1:D_WIDTH],
                         fixed_quotient_w[FN_W-1:D_WIDTH], fixed_remainder_w[FN_W-1:D_WIDTH]};

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: request/response front-end for the iterative divider stage.
//   i_clk, i_rstn                  : clock and async active-low reset (shared with the divider)
//   i_valid/o_ready, i_dividend/i_divisor        : request channel
//   o_valid/i_ready, o_quotient/o_remainder/o_div_by_zero : result channel
//   o_div_start, o_div_dividend/o_div_divisor    : divider launch (magnitudes)
//   i_div_done, i_div_quotient/i_div_remainder   : divider completion
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Valid never depends on ready. While o_valid is high, the result is held
// stable until it is taken.
module div_ctrl
    import div_pkg::*;
#(
    parameter int D_WIDTH = 4,
    parameter int SIGNED  = 0
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [D_WIDTH-1:0] i_dividend,
    input  logic [D_WIDTH-1:0] i_divisor,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [D_WIDTH-1:0] o_quotient,
    output logic [D_WIDTH-1:0] o_remainder,
    output logic               o_div_by_zero,
    output logic               o_div_start,
    output logic [D_WIDTH-1:0] o_div_dividend,
    output logic [D_WIDTH-1:0] o_div_divisor,
    input  logic               i_div_done,
    input  logic [D_WIDTH-1:0] i_div_quotient,
    input  logic [D_WIDTH-1:0] i_div_remainder
);

    div_state_e state;
    div_state_e state_next;

    logic               quot_neg_q;
    logic               rem_neg_q;
    logic               quot_neg;
    logic               rem_neg;
    logic [D_WIDTH-1:0] mag_dividend;
    logic [D_WIDTH-1:0] mag_divisor;
    logic [D_WIDTH-1:0] fixed_quotient;
    logic [D_WIDTH-1:0] fixed_remainder;
    logic               accept;
    logic               capture;

    div_sign_adjust #(
        .D_WIDTH (D_WIDTH),
        .SIGNED  (SIGNED)
    ) u_sign_adjust (
        .dividend        (i_dividend),
        .divisor         (i_divisor),
        .mag_dividend    (mag_dividend),
        .mag_divisor     (mag_divisor),
        .quot_neg        (quot_neg),
        .rem_neg         (rem_neg),
        .div_quotient    (i_div_quotient),
        .div_remainder   (i_div_remainder),
        .quot_neg_q      (quot_neg_q),
        .rem_neg_q       (rem_neg_q),
        .fixed_quotient  (fixed_quotient),
        .fixed_remainder (fixed_remainder)
    );

    assign accept = o_ready && i_valid;
    // A done seen in BUSY is always fresh, because the start sampled at the end
    // of LAUNCH cleared any stale done. Leaving BUSY on that same edge means the
    // later, corrupted done cycles are never captured.
    assign capture = (state == BUSY) && i_div_done;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        o_div_start = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    state_next = (i_divisor == '0) ? RESULT : LAUNCH;
                end
            end
            LAUNCH: begin
                o_div_start = 1'b1;
                state_next  = BUSY;
            end
            BUSY: begin
                if (i_div_done) begin
                    state_next = RESULT;
                end
            end
            RESULT: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The divider reads the divisor every iteration, so the operand registers
    // only change on accept.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_div_dividend <= '0;
            o_div_divisor  <= '0;
            quot_neg_q     <= 1'b0;
            rem_neg_q      <= 1'b0;
            o_quotient     <= '0;
            o_remainder    <= '0;
            o_div_by_zero  <= 1'b0;
        end else if (accept) begin
            o_div_dividend <= mag_dividend;
            o_div_divisor  <= mag_divisor;
            quot_neg_q     <= quot_neg;
            rem_neg_q      <= rem_neg;
            if (i_divisor == '0) begin
                o_quotient    <= DIV_ZERO_Q[D_WIDTH-1:0];
                o_remainder   <= i_dividend;
                o_div_by_zero <= 1'b1;
            end
        end else if (capture) begin
            o_quotient    <= fixed_quotient;
            o_remainder   <= fixed_remainder;
            o_div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
`timescale 1ns/1ps
// Two controller instances: lane 0 is unsigned and lane 1 is signed. Each
// lane has a small iterative-divider model. The model raises done W-1 edges
// after it samples start, then keeps changing its outputs afterwards.
module tb_div_ctrl;

    localparam int W     = 4;
    localparam int EXP_W = 17;   // {lat[7:0], dbz, q[3:0], r[3:0]}
    localparam int LAT   = W + 2;
    localparam int TMO   = 200;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic         in_valid [2];
    logic [W-1:0] in_dvd   [2];
    logic [W-1:0] in_dvs   [2];
    logic         out_rdy  [2];
    logic         res_valid[2];
    logic         res_rdy  [2];
    logic [W-1:0] res_q    [2];
    logic [W-1:0] res_r    [2];
    logic         res_dbz  [2];
    logic         div_start[2];
    logic [W-1:0] div_dvd  [2];
    logic [W-1:0] div_dvs  [2];
    logic         div_done [2];
    logic [W-1:0] div_q    [2];
    logic [W-1:0] div_r    [2];
    logic [W-1:0] div_a    [2];
    int           div_cnt  [2];

    div_ctrl #(.D_WIDTH(W), .SIGNED(0)) u_dut_u (
        .i_clk(clk), .i_rstn(rstn),
        .i_valid(in_valid[0]), .o_ready(out_rdy[0]),
        .i_dividend(in_dvd[0]), .i_divisor(in_dvs[0]),
        .o_valid(res_valid[0]), .i_ready(res_rdy[0]),
        .o_quotient(res_q[0]), .o_remainder(res_r[0]), .o_div_by_zero(res_dbz[0]),
        .o_div_start(div_start[0]), .o_div_dividend(div_dvd[0]), .o_div_divisor(div_dvs[0]),
        .i_div_done(div_done[0]), .i_div_quotient(div_q[0]), .i_div_remainder(div_r[0])
    );

    div_ctrl #(.D_WIDTH(W), .SIGNED(1)) u_dut_s (
        .i_clk(clk), .i_rstn(rstn),
        .i_valid(in_valid[1]), .o_ready(out_rdy[1]),
        .i_dividend(in_dvd[1]), .i_divisor(in_dvs[1]),
        .o_valid(res_valid[1]), .i_ready(res_rdy[1]),
        .o_quotient(res_q[1]), .o_remainder(res_r[1]), .o_div_by_zero(res_dbz[1]),
        .o_div_start(div_start[1]), .o_div_dividend(div_dvd[1]), .o_div_divisor(div_dvs[1]),
        .i_div_done(div_done[1]), .i_div_quotient(div_q[1]), .i_div_remainder(div_r[1])
    );

    // Iterative divider model: the first iteration happens on the start edge and
    // done rises with the last one. The divisor is read live at the end.
    always @(posedge clk or negedge rstn) begin
        for (int l = 0; l < 2; l++) begin
            if (!rstn) begin
                div_done[l] <= 1'b0;
                div_cnt[l]  <= 0;
                div_q[l]    <= '0;
                div_r[l]    <= '0;
                div_a[l]    <= '0;
            end else if (div_start[l]) begin
                div_done[l] <= 1'b0;
                div_cnt[l]  <= W - 1;
                div_a[l]    <= div_dvd[l];
            end else if (div_cnt[l] != 0) begin
                div_cnt[l] <= div_cnt[l] - 1;
                if (div_cnt[l] == 1) begin
                    div_done[l] <= 1'b1;
                    div_q[l]    <= div_a[l] / div_dvs[l];
                    div_r[l]    <= div_a[l] % div_dvs[l];
                end
            end else if (div_done[l]) begin
                div_q[l] <= div_q[l] + 1'b1;
                div_r[l] <= div_r[l] ^ 4'h1;
            end
        end
    end

    // Scoreboard queues, one set per lane.
    logic [EXP_W-1:0] exp_q0[$];
    logic [EXP_W-1:0] exp_q1[$];
    int               acc_q0[$];
    int               acc_q1[$];
    int               start_q0[$];
    int               start_q1[$];

    // Reference model, computed directly from the arithmetic definition.
    function automatic logic [EXP_W-1:0] model(input int sgn, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        int ia, ib, q, r;
        logic [W-1:0] qq, rr;
        if (b == '0) begin
            return {8'd1, 1'b1, 4'hF, a};
        end
        if (sgn != 0) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'(a);
            ib = int'(b);
        end
        q  = ia / ib;
        r  = ia % ib;
        qq = q[W-1:0];
        rr = r[W-1:0];
        return {8'(LAT), 1'b0, qq, rr};
    endfunction

    function automatic bit pop_exp(input int ln, output logic [EXP_W-1:0] e, output int acc);
        e = '0;
        acc = 0;
        if (ln == 0) begin
            if (exp_q0.size() == 0) return 1'b0;
            e = exp_q0.pop_front();
            acc = acc_q0.pop_front();
        end else begin
            if (exp_q1.size() == 0) return 1'b0;
            e = exp_q1.pop_front();
            acc = acc_q1.pop_front();
        end
        return 1'b1;
    endfunction

    function automatic bit pop_start(input int ln, output int st);
        st = 0;
        if (ln == 0) begin
            if (start_q0.size() == 0) return 1'b0;
            st = start_q0.pop_front();
        end else begin
            if (start_q1.size() == 0) return 1'b0;
            st = start_q1.pop_front();
        end
        return 1'b1;
    endfunction

    function automatic int exp_size(input int ln);
        return (ln == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic chk(input string name, input int ln, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s lane%0d got=%0h want=%0h t=%0t", name, ln, act, exp, $time);
        end
    endtask

    // Monitor: runs on every falling edge. It checks start pulses, the first
    // presentation of each result, and that the result stays stable while held.
    bit         have      [2];
    logic [8:0] held      [2];
    logic       prev_start[2];

    task automatic mon(input int ln);
        logic [EXP_W-1:0] e;
        int               acc, st;
        logic [8:0]       cur;
        if (!rstn) begin
            have[ln]       = 1'b0;
            prev_start[ln] = 1'b0;
            return;
        end
        cur = {res_dbz[ln], res_q[ln], res_r[ln]};
        if (div_start[ln]) begin
            chk("start_width", ln, int'(prev_start[ln]), 0);
            if (!pop_start(ln, st)) chk("start_unexpected", ln, 1, 0);
            else                    chk("start_cycle", ln, cyc, st);
        end
        prev_start[ln] = div_start[ln];
        if (res_valid[ln]) begin
            if (!have[ln]) begin
                if (!pop_exp(ln, e, acc)) begin
                    chk("result_unexpected", ln, int'(cur), -1);
                end else begin
                    chk("result", ln, int'(cur), int'(e[8:0]));
                    chk("latency", ln, cyc - acc, int'(e[16:9]) - 1);
                end
                have[ln] = 1'b1;
                held[ln] = cur;
            end else begin
                chk("result_hold", ln, int'(cur), int'(held[ln]));
            end
            if (res_rdy[ln]) have[ln] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // Driver: called on a falling edge. It presents a request and, once it
    // sees o_ready, records the expected result against the accepting edge.
    task automatic send(input int ln, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold);
        int t = 0;
        logic [EXP_W-1:0] e;
        in_valid[ln] = 1'b1;
        in_dvd[ln]   = a;
        in_dvs[ln]   = b;
        while (!out_rdy[ln] && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TMO) begin
            chk("accept_timeout", ln, t, 0);
            in_valid[ln] = 1'b0;
            return;
        end
        e = model(ln, a, b);
        if (ln == 0) begin
            exp_q0.push_back(e);
            acc_q0.push_back(cyc + 1);
            if (b != '0) start_q0.push_back(cyc + 1);
        end else begin
            exp_q1.push_back(e);
            acc_q1.push_back(cyc + 1);
            if (b != '0) start_q1.push_back(cyc + 1);
        end
        @(negedge clk);
        if (!hold) in_valid[ln] = 1'b0;
    endtask

    task automatic wait_idle(input int ln);
        int t = 0;
        while ((exp_size(ln) != 0 || !out_rdy[ln]) && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TMO) chk("drain_timeout", ln, t, 0);
    endtask

    task automatic chk_reset(input int ln);
        chk("rst_ready", ln, int'(out_rdy[ln]), 1);
        chk("rst_valid", ln, int'(res_valid[ln]), 0);
        chk("rst_start", ln, int'(div_start[ln]), 0);
        chk("rst_dbz", ln, int'(res_dbz[ln]), 0);
        chk("rst_q", ln, int'(res_q[ln]), 0);
        chk("rst_r", ln, int'(res_r[ln]), 0);
        chk("rst_div_dvd", ln, int'(div_dvd[ln]), 0);
        chk("rst_div_dvs", ln, int'(div_dvs[ln]), 0);
    endtask

    initial begin
        int t;
        logic [W-1:0] a, b;
        rstn = 1'b1;
        for (int l = 0; l < 2; l++) begin
            in_valid[l] = 1'b0;
            in_dvd[l]   = '0;
            in_dvs[l]   = '0;
            res_rdy[l]  = 1'b1;
        end
        #1 rstn = 1'b0;
        #20;
        chk_reset(0);
        chk_reset(1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Unsigned nominal case and divide-by-zero.
        send(0, 4'd13, 4'd3, 1'b0);
        wait_idle(0);
        send(0, 4'd9, 4'd0, 1'b0);
        wait_idle(0);

        // Signed cases, including MIN / -1 and a signed zero divisor.
        send(1, 4'h9, 4'h2, 1'b0);
        wait_idle(1);
        send(1, 4'h7, 4'hE, 1'b0);
        wait_idle(1);
        send(1, 4'h8, 4'hF, 1'b0);
        wait_idle(1);
        send(1, 4'hA, 4'h0, 1'b0);
        wait_idle(1);

        // Backpressure: the result is held and a competing request is refused.
        res_rdy[0] = 1'b0;
        send(0, 4'd6, 4'd4, 1'b0);
        t = 0;
        while (!res_valid[0] && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TMO) chk("bp_valid_timeout", 0, t, 0);
        in_valid[0] = 1'b1;
        in_dvd[0]   = 4'd3;
        in_dvs[0]   = 4'd1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_low", 0, int'(out_rdy[0]), 0);
            @(negedge clk);
        end
        in_valid[0] = 1'b0;
        res_rdy[0]  = 1'b1;
        wait_idle(0);
        send(0, 4'd15, 4'd5, 1'b0);
        wait_idle(0);

        // Reset two cycles after the start pulse, while the divider is busy.
        send(0, 4'd14, 4'd3, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk_reset(0);
        exp_q0.delete();
        acc_q0.delete();
        start_q0.delete();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        send(0, 4'd10, 4'd3, 1'b0);
        wait_idle(0);

        // Back-to-back random traffic with valid held high, on both lanes.
        for (int l = 0; l < 2; l++) begin
            for (int i = 0; i < 8; i++) begin
                a = W'($urandom_range(0, 15));
                b = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom_range(1, 15));
                send(l, a, b, 1'b1);
            end
            in_valid[l] = 1'b0;
            wait_idle(l);
        end

        repeat (4) @(negedge clk);
        chk("leftover_exp", 0, exp_q0.size() + start_q0.size(), 0);
        chk("leftover_exp", 1, exp_q1.size() + start_q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
